// File: rtl/pixel_pkg.sv
// Shared pixel types for the edge-detector pipeline.
// Holds the column height, the RGB pixel struct, the column array type and
// the colour-channel enum used by byte-serial links between pipeline stages.
package pixel_pkg;

  localparam int PixelHeight = 5;
  localparam int ColorWidth  = 8;

  typedef struct packed {
    logic [ColorWidth-1:0] red;
    logic [ColorWidth-1:0] green;
    logic [ColorWidth-1:0] blue;
  } Pixel;

  // Element 0 is the first pixel received (top of the column).
  typedef Pixel [0:PixelHeight-1] PixelArray;

  typedef enum logic [1:0] {
    RED   = 2'd0,
    GREEN = 2'd1,
    BLUE  = 2'd2
  } Channel;

endpackage

// File: rtl/pixel_column_reader.sv
// pixel_column_reader
// Reassembles a byte stream (red, green, blue per pixel, pixel 0 first) into
// full PixelArray columns. Framing is checked with an optional start-of-column
// marker; a misplaced marker resynchronises the stream and raises a sticky
// error flag.
//
// Ports:
//   clock        in   rising-edge clock
//   resetN       in   asynchronous active-low reset
//   byteData     in   stream byte
//   byteValid    in   byteData valid
//   byteStart    in   byte is red of pixel 0
//   byteReady    out  byte accepted this cycle when byteValid is high
//   columnData   out  assembled column (held while not accepted)
//   columnValid  out  columnData valid
//   columnReady  in   downstream accepts the column
//   syncError    out  sticky framing error
//   errorClear   in   clears syncError (a new error in the same cycle wins)
//   columnCount  out  number of columns delivered, wraps
//
// The PixelHeight and ColorWidth parameters must match the pixel_pkg values,
// since the column port uses the shared PixelArray type.
module pixel_column_reader #(
  parameter int PixelHeight = pixel_pkg::PixelHeight,
  parameter int ColorWidth  = pixel_pkg::ColorWidth,
  parameter int CountWidth  = 16
) (
  input  logic                   clock,
  input  logic                   resetN,
  input  logic [ColorWidth-1:0]  byteData,
  input  logic                   byteValid,
  input  logic                   byteStart,
  output logic                   byteReady,
  output pixel_pkg::PixelArray   columnData,
  output logic                   columnValid,
  input  logic                   columnReady,
  output logic                   syncError,
  input  logic                   errorClear,
  output logic [CountWidth-1:0]  columnCount
);

  import pixel_pkg::*;

  localparam int IdxW = (PixelHeight > 1) ? $clog2(PixelHeight) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(PixelHeight - 1);
  localparam logic [IdxW-1:0] ZeroIdx = {IdxW{1'b0}};

  Channel                 state_q, state_d;
  logic [IdxW-1:0]        index_q, index_d;
  PixelArray              stage_q, stage_d;
  PixelArray              col_data_q, col_data_d;
  logic                   col_valid_q, col_valid_d;
  logic                   sync_err_q, sync_err_d;
  logic [CountWidth-1:0]  count_q, count_d;

  logic out_free_s;
  logic at_last_s;
  logic at_origin_s;
  logic byte_ready_s;
  logic accept_s;
  logic err_set_s;
  logic complete_s;

  // Handshake qualifiers: stall only the column-completing byte when the output is occupied.
  always_comb begin
    out_free_s   = !col_valid_q || columnReady;
    at_last_s    = (state_q == BLUE) && (index_q == LastIdx);
    at_origin_s  = (state_q == RED) && (index_q == ZeroIdx);
    byte_ready_s = !(at_last_s && !out_free_s);
    accept_s     = byteValid && byte_ready_s;
  end

  // Channel FSM, staging writes and resynchronisation on a misplaced start marker.
  always_comb begin
    state_d    = state_q;
    index_d    = index_q;
    stage_d    = stage_q;
    err_set_s  = 1'b0;
    complete_s = 1'b0;
    if (accept_s) begin
      if (byteStart && !at_origin_s) begin
        // Drop the partial column and treat this byte as red of pixel 0.
        stage_d        = '0;
        stage_d[0].red = byteData;
        state_d        = GREEN;
        index_d        = ZeroIdx;
        err_set_s      = 1'b1;
      end else begin
        case (state_q)
          RED: begin
            stage_d[index_q].red = byteData;
            state_d              = GREEN;
          end
          GREEN: begin
            stage_d[index_q].green = byteData;
            state_d                = BLUE;
          end
          BLUE: begin
            stage_d[index_q].blue = byteData;
            state_d               = RED;
            if (index_q == LastIdx) begin
              index_d    = ZeroIdx;
              complete_s = 1'b1;
            end else begin
              index_d = index_q + IdxW'(1);
            end
          end
          default: begin
            state_d = RED;
            index_d = ZeroIdx;
          end
        endcase
      end
    end else begin
      state_d = state_q;
    end
  end

  // Output register, sticky error flag and delivered-column counter.
  always_comb begin
    col_data_d  = col_data_q;
    col_valid_d = col_valid_q;
    sync_err_d  = sync_err_q;
    count_d     = count_q;
    // stage_d already contains the completing byte.
    if (complete_s) begin
      col_data_d  = stage_d;
      col_valid_d = 1'b1;
    end else if (col_valid_q && columnReady) begin
      col_valid_d = 1'b0;
    end else begin
      col_valid_d = col_valid_q;
    end
    if (err_set_s) begin
      sync_err_d = 1'b1;
    end else if (errorClear) begin
      sync_err_d = 1'b0;
    end else begin
      sync_err_d = sync_err_q;
    end
    if (col_valid_q && columnReady) begin
      count_d = count_q + CountWidth'(1);
    end else begin
      count_d = count_q;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q     <= RED;
      index_q     <= ZeroIdx;
      stage_q     <= '0;
      col_data_q  <= '0;
      col_valid_q <= 1'b0;
      sync_err_q  <= 1'b0;
      count_q     <= {CountWidth{1'b0}};
    end else begin
      state_q     <= state_d;
      index_q     <= index_d;
      stage_q     <= stage_d;
      col_data_q  <= col_data_d;
      col_valid_q <= col_valid_d;
      sync_err_q  <= sync_err_d;
      count_q     <= count_d;
    end
  end

  assign byteReady   = byte_ready_s;
  assign columnData  = col_data_q;
  assign columnValid = col_valid_q;
  assign syncError   = sync_err_q;
  assign columnCount = count_q;

endmodule

// File: tb/tb_pixel_column_reader.sv
// Directed testbench for pixel_column_reader (CountWidth = 4 so the delivered
// column counter can be wrapped in a short run).
module tb_pixel_column_reader;

  localparam int CW = 4;

  logic                  clock;
  logic                  resetN;
  logic [7:0]            byteData;
  logic                  byteValid;
  logic                  byteStart;
  logic                  byteReady;
  pixel_pkg::PixelArray  columnData;
  logic                  columnValid;
  logic                  columnReady;
  logic                  syncError;
  logic                  errorClear;
  logic [CW-1:0]         columnCount;

  int total;
  int bad;
  pixel_pkg::PixelArray got[$];

  pixel_column_reader #(.CountWidth(CW)) dut (
    .clock       (clock),
    .resetN      (resetN),
    .byteData    (byteData),
    .byteValid   (byteValid),
    .byteStart   (byteStart),
    .byteReady   (byteReady),
    .columnData  (columnData),
    .columnValid (columnValid),
    .columnReady (columnReady),
    .syncError   (syncError),
    .errorClear  (errorClear),
    .columnCount (columnCount)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Expected column whose byte stream starts at base and increments by one.
  function automatic pixel_pkg::PixelArray make_col(input logic [7:0] base);
    pixel_pkg::PixelArray c;
    for (int p = 0; p < 5; p++) begin
      c[p].red   = base + 8'(3 * p);
      c[p].green = base + 8'(3 * p + 1);
      c[p].blue  = base + 8'(3 * p + 2);
    end
    return c;
  endfunction

  // One clock; outputs sampled 1 time unit after the edge. Delivered columns are logged.
  task automatic step();
    @(posedge clock);
    #1;
    if (columnValid && columnReady) got.push_back(columnData);
  endtask

  task automatic do_reset();
    byteValid = 1'b0;
    byteStart = 1'b0;
    errorClear = 1'b0;
    byteData = 8'h00;
    resetN = 1'b0;
    step();
    step();
    resetN = 1'b1;
    step();
    got.delete();
  endtask

  // Offer one byte and wait (bounded) until it is accepted.
  task automatic send_byte(input logic [7:0] b, input logic st);
    int n;
    byteValid = 1'b1;
    byteData  = b;
    byteStart = st;
    #1;
    n = 0;
    while (byteReady !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    if (n >= 20) begin
      bad++;
      $display("FAIL send_byte_timeout: byteReady=%b required 1", byteReady);
    end
    total++;
    step();
    byteValid = 1'b0;
    byteStart = 1'b0;
  endtask

  task automatic test_reset();
    pixel_pkg::PixelArray zero_col;
    zero_col = '0;
    do_reset();
    total++; if (byteReady !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", byteReady); end
    total++; if (columnValid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", columnValid); end
    total++; if (columnCount !== 4'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", columnCount); end
    total++; if (syncError !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", syncError); end
    // Mid-stream reset with a column held at the output and a partial one staged.
    columnReady = 1'b0;
    for (int i = 0; i < 22; i++) send_byte(8'(i + 1), (i == 0 || i == 15) ? 1'b1 : 1'b0);
    total++; if (columnValid !== 1'b1) begin bad++; $display("FAIL pre_reset_held: got %b want 1", columnValid); end
    resetN = 1'b0;
    #1;
    total++; if (columnValid !== 1'b0) begin bad++; $display("FAIL midreset_valid: got %b want 0", columnValid); end
    total++; if (columnData !== zero_col) begin bad++; $display("FAIL midreset_data: got %h want 0", columnData); end
    total++; if (byteReady !== 1'b1) begin bad++; $display("FAIL midreset_ready: got %b want 1", byteReady); end
    step();
    step();
    resetN = 1'b1;
    columnReady = 1'b1;
    step();
    got.delete();
    begin
      logic early;
      early = 1'b0;
      for (int i = 0; i < 14; i++) begin
        send_byte(8'h41 + 8'(i), 1'b0);
        if (columnValid !== 1'b0) early = 1'b1;
      end
      total++; if (early !== 1'b0) begin bad++; $display("FAIL postreset_early_column: got %b want 0", early); end
    end
    send_byte(8'h4F, 1'b0);
    total++; if (columnValid !== 1'b1) begin bad++; $display("FAIL postreset_valid: got %b want 1", columnValid); end
    total++; if (columnData !== make_col(8'h41)) begin bad++; $display("FAIL postreset_data: got %h want %h", columnData, make_col(8'h41)); end
  endtask

  task automatic test_basic();
    do_reset();
    columnReady = 1'b1;
    for (int i = 0; i < 14; i++) send_byte(8'(i + 1), (i == 0) ? 1'b1 : 1'b0);
    total++; if (columnValid !== 1'b0) begin bad++; $display("FAIL basic_valid_early: got %b want 0", columnValid); end
    send_byte(8'h0F, 1'b0);
    total++; if (columnValid !== 1'b1) begin bad++; $display("FAIL basic_valid: got %b want 1", columnValid); end
    total++; if (columnData[0] !== 24'h010203) begin bad++; $display("FAIL basic_pix0: got %h want 010203", columnData[0]); end
    total++; if (columnData[4] !== 24'h0D0E0F) begin bad++; $display("FAIL basic_pix4: got %h want 0d0e0f", columnData[4]); end
    total++; if (syncError !== 1'b0) begin bad++; $display("FAIL basic_err: got %b want 0", syncError); end
    step();
    total++; if (columnValid !== 1'b0) begin bad++; $display("FAIL basic_pulse: got %b want 0", columnValid); end
    total++; if (columnCount !== 4'd1) begin bad++; $display("FAIL basic_count: got %0d want 1", columnCount); end
  endtask

  task automatic test_backpressure();
    do_reset();
    columnReady = 1'b0;
    for (int i = 0; i < 29; i++) send_byte(8'(i + 1), (i == 0 || i == 15) ? 1'b1 : 1'b0);
    total++; if (columnData !== make_col(8'h01)) begin bad++; $display("FAIL bp_held: got %h want %h", columnData, make_col(8'h01)); end
    byteValid = 1'b1;
    byteData  = 8'h1E;
    #1;
    total++; if (byteReady !== 1'b0) begin bad++; $display("FAIL bp_stall: got %b want 0", byteReady); end
    step();
    total++; if (columnData !== make_col(8'h01)) begin bad++; $display("FAIL bp_stable: got %h want %h", columnData, make_col(8'h01)); end
    total++; if (columnCount !== 4'd0) begin bad++; $display("FAIL bp_count0: got %0d want 0", columnCount); end
    columnReady = 1'b1;
    #1;
    total++; if (byteReady !== 1'b1) begin bad++; $display("FAIL bp_release: got %b want 1", byteReady); end
    step();
    byteValid = 1'b0;
    columnReady = 1'b0;
    total++; if (columnValid !== 1'b1) begin bad++; $display("FAIL bp_valid_stays: got %b want 1", columnValid); end
    total++; if (columnData !== make_col(8'h10)) begin bad++; $display("FAIL bp_second: got %h want %h", columnData, make_col(8'h10)); end
    total++; if (columnCount !== 4'd1) begin bad++; $display("FAIL bp_count1: got %0d want 1", columnCount); end
    columnReady = 1'b1;
    step();
    total++; if (columnCount !== 4'd2) begin bad++; $display("FAIL bp_count2: got %0d want 2", columnCount); end
  endtask

  task automatic test_resync();
    logic early;
    do_reset();
    columnReady = 1'b1;
    for (int i = 0; i < 6; i++) send_byte(8'(i + 1), (i == 0) ? 1'b1 : 1'b0);
    total++; if (syncError !== 1'b0) begin bad++; $display("FAIL resync_noerr: got %b want 0", syncError); end
    send_byte(8'h07, 1'b1);
    total++; if (syncError !== 1'b1) begin bad++; $display("FAIL resync_err: got %b want 1", syncError); end
    early = 1'b0;
    for (int i = 8; i < 21; i++) begin
      send_byte(8'(i), 1'b0);
      if (columnValid !== 1'b0) early = 1'b1;
    end
    total++; if (early !== 1'b0) begin bad++; $display("FAIL resync_early_column: got %b want 0", early); end
    send_byte(8'h15, 1'b0);
    total++; if (columnValid !== 1'b1) begin bad++; $display("FAIL resync_valid: got %b want 1", columnValid); end
    total++; if (columnData !== make_col(8'h07)) begin bad++; $display("FAIL resync_data: got %h want %h", columnData, make_col(8'h07)); end
    errorClear = 1'b1;
    step();
    errorClear = 1'b0;
    total++; if (syncError !== 1'b0) begin bad++; $display("FAIL resync_clear: got %b want 0", syncError); end
    send_byte(8'h31, 1'b1);
    total++; if (syncError !== 1'b0) begin bad++; $display("FAIL resync_legal_start: got %b want 0", syncError); end
    send_byte(8'h32, 1'b0);
    errorClear = 1'b1;
    send_byte(8'h33, 1'b1);
    errorClear = 1'b0;
    total++; if (syncError !== 1'b1) begin bad++; $display("FAIL resync_set_wins: got %b want 1", syncError); end
  endtask

  task automatic test_gapped();
    do_reset();
    columnReady = 1'b1;
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < 15; i++) begin
        if ($urandom_range(0, 1) == 1) step();
        send_byte(8'(i + 1), (i == 0) ? 1'b1 : 1'b0);
      end
    end
    step();
    step();
    total++; if (got.size() !== 3) begin bad++; $display("FAIL gap_columns: got %0d want 3", got.size()); end
    for (int k = 0; k < got.size(); k++) begin
      total++;
      if (got[k] !== make_col(8'h01)) begin bad++; $display("FAIL gap_data%0d: got %h want %h", k, got[k], make_col(8'h01)); end
    end
    total++; if (columnCount !== 4'd3) begin bad++; $display("FAIL gap_count: got %0d want 3", columnCount); end
  endtask

  task automatic test_back_to_back_wrap();
    do_reset();
    columnReady = 1'b1;
    for (int c = 0; c < 16; c++) begin
      for (int i = 0; i < 15; i++) send_byte(8'h20 + 8'(i), (i == 0) ? 1'b1 : 1'b0);
    end
    total++; if (columnCount !== 4'd15) begin bad++; $display("FAIL wrap_count15: got %0d want 15", columnCount); end
    total++; if (columnData !== make_col(8'h20)) begin bad++; $display("FAIL wrap_data: got %h want %h", columnData, make_col(8'h20)); end
    step();
    total++; if (columnCount !== 4'd0) begin bad++; $display("FAIL wrap_count0: got %0d want 0", columnCount); end
    total++; if (got.size() !== 16) begin bad++; $display("FAIL wrap_columns: got %0d want 16", got.size()); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    resetN = 1'b0;
    byteData = 8'h00;
    byteValid = 1'b0;
    byteStart = 1'b0;
    columnReady = 1'b1;
    errorClear = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_resync();
    test_gapped();
    test_back_to_back_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pixel_column_reader.md
# pixel_column_reader

Receive-side counterpart of the edge-detector image output. The detector emits one RGB pixel as three consecutive bytes (red, green, blue). This block accepts that byte stream, one byte per cycle under a valid/ready handshake, and reassembles it into full `PixelArray` columns for the front of the detection pipeline. Framing loss is detected with a start-of-column marker and reported through a sticky error flag.

## Interface
- `PixelHeight`, default from shared package (5): pixels per column.
- `ColorWidth`, default 8: bits per colour channel; byte width equals `ColorWidth`.
- `CountWidth`, default 16: width of delivered-column counter.

- `clock`  in  1  single clock, rising edge.
- `resetN`  in  1  asynchronous, active-low reset.
- `byteData`  in  ColorWidth  stream byte.
- `byteValid`  in  1  `byteData` valid.
- `byteStart`  in  1  qualifies current byte as red of pixel 0 (start of column).
- `byteReady`  out  1  block accepts byte this cycle.
- `columnData`  out  PixelArray  assembled column, pixel 0 = first received.
- `columnValid`  out  1  `columnData` valid.
- `columnReady`  in  1  downstream accepts column.
- `syncError`  out  1  sticky framing error.
- `errorClear`  in  1  clears `syncError`.
- `columnCount`  out  CountWidth  number of columns delivered.

## Operation
- Byte accepted when `byteValid && byteReady`.
- Channel FSM, states RED -> GREEN -> BLUE -> RED, advancing on each accepted byte. Pixel index 0..PixelHeight-1 increments on BLUE acceptance and wraps to 0 after the last pixel.
- Accepted bytes are written into a staging `PixelArray` at the current (index, channel).
- Column completion: the accepted byte is BLUE of pixel PixelHeight-1. In that cycle the staging array, including the current byte, is loaded into the `columnData` output register, `columnValid` is set, and the FSM returns to RED / index 0.
- Output register is free when `!columnValid || columnReady`. `byteReady` is 0 only when the FSM is at BLUE / last index and the output register is not free; otherwise it is 1.
- Completion in the same cycle as a downstream accept (`columnValid && columnReady`): the register loads the new column and `columnValid` stays 1.
- `columnData` is held stable while `columnValid && !columnReady`.
- `byteStart` on an accepted byte:
  - FSM at RED / index 0: normal, no error.
  - Any other position: partial column is discarded, the byte is stored as red of pixel 0, FSM goes to GREEN / index 0, and `syncError` is set.
- Accepted byte with `byteStart` = 0 at RED / index 0 is legal; markers are optional.
- `errorClear` clears `syncError`. If a new error occurs in the same cycle, set wins.
- `columnCount` increments on each `columnValid && columnReady` and wraps from all-ones to 0.

## Timing
- Reset (async assert, sync-safe deassert):
  - FSM RED, index 0.
  - Staging array 0, `columnData` 0.
  - `columnValid` 0, `syncError` 0, `columnCount` 0.
  - `byteReady` 1.
- Latency: `columnValid` rises the cycle after the last byte of a column is accepted.
- Throughput: one column per 3·PixelHeight accepted bytes; no bubbles with a continuous stream and `columnReady` = 1.
- `syncError` is visible the cycle after the offending byte.
- Reset mid-column discards the partial column and any held output. No column is emitted after reset until a full 3·PixelHeight bytes arrive.

## Structure
- Shared package `pixel_pkg` holds:
  - `PixelHeight`.
  - `Pixel` struct {red, green, blue}, each `ColorWidth` bits.
  - `PixelArray` = `Pixel [0:PixelHeight-1]`.
  - Channel enum {RED, GREEN, BLUE}.
- These are the same typedefs the detector pipeline uses.
- No sub-module: the FSM, staging array and output register stay flat in one module.

## Test plan
- Reset: assert `resetN` = 0 mid-stream → all outputs at reset values, `byteReady` = 1, no spurious `columnValid`.
- Basic column: bytes 0x01..0x0F back-to-back, `byteStart` on 0x01, `columnReady` = 1 → `columnValid` pulses one cycle after 0x0F; pixel0 = {01,02,03}, pixel4 = {0D,0E,0F}; `columnCount` = 1.
- Backpressure: `columnReady` = 0, stream 30 bytes → first column held stable; `byteReady` = 0 with byte 30 pending. After `columnReady` = 1 for one cycle, the second column is loaded, `columnValid` stays 1, and `columnCount` = 1.
- Resync: `byteStart` on the 7th byte of a column → `syncError` = 1; the next column is bytes 7..21, pixel0 = byte 7. `errorClear` clears `syncError`; `errorClear` coinciding with a new misplaced `byteStart` leaves `syncError` = 1.
- Gapped stream: `byteValid` random 50 % over 3 columns → data identical to the back-to-back case, 3 columns delivered.
- Counter wrap: force 2^CountWidth deliveries (`CountWidth` = 4, i.e. 16 columns) → `columnCount` returns to 0.
